// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
//   state_t    : transmitter FSM states
//   PAR_*      : parity mode encodings for the PARITY parameter
//   parity_bit : parity of a data word (zero-padded to MAX_DATA_BITS)
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Zero padding of narrow words does not change the XOR result.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int unsigned              mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clk, rst   : clock, asynchronous active-high reset (flushes contents)
//   push       : write request; accepted only when not full
//   push_data  : word to write
//   pop        : read request; honoured only when not empty
//   pop_data   : current head word
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses a push even if a pop happens on the same edge.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with input FIFO; frames leave back-to-back
// while words are queued.
//   clk, rst      : clock, asynchronous active-high reset (aborts frame, flushes FIFO)
//   div           : clocks per bit minus 1, latched when a frame starts
//   s_data/s_valid/s_ready : word input handshake, s_ready = FIFO not full
//   tx            : serial line, idle high, LSB first
//   busy          : frame in progress
//   tx_done_tick  : one-cycle pulse in the cycle after the last stop clock
//   fifo_count    : current FIFO occupancy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIV_W-1:0]        div,
  input  logic [DATA_BITS-1:0]    s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done_tick,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   pop;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   head;
  logic                   full;
  logic                   empty;
  logic [MAX_DATA_BITS-1:0] head_ext;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign s_ready      = !full;
  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);
  assign tx_done_tick = done_q;
  assign bit_end      = (baud_q == div_q);

  always_comb begin
    head_ext = '0;
    head_ext[DATA_BITS-1:0] = head;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (!empty) begin
              state_d = START;
              pop     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading the head word also fixes its parity for the whole frame.
    if (pop) begin
      baud_d  = '0;
      shift_d = head;
      par_d   = parity_bit(head_ext, PARITY);
    end

    // tx is registered from the next state so the line changes on the
    // same edge as the state it belongs to.
    case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_d;
      default:          tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      if (pop) div_q <= div;
    end
  end

endmodule
